// File: rtl/regfile_n.sv
// Parametrised register file: DEPTH x WIDTH flops, one byte-strobed write port,
// two combinational read ports with optional write bypass and hardwired zero entry.
module regfile_n #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH/8-1:0]   wr_strb,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_W-1:0]    rd_addr_a,
    output logic [WIDTH-1:0]     rd_data_a,
    input  logic [ADDR_W-1:0]    rd_addr_b,
    output logic [WIDTH-1:0]     rd_data_b
);

    localparam int unsigned NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] view [DEPTH];

    // Per-entry decode: addresses >= DEPTH match no entry, so they never alias.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        if (ZERO_REG != 0 && g == 0) begin : g_zero
            assign view[g] = '0;
        end else begin : g_reg
            logic             we;
            logic [WIDTH-1:0] nxt;

            assign we = reset && wr_en && (wr_addr == ADDR_W'(g));

            always_comb begin
                nxt = mem[g];
                for (int unsigned k = 0; k < NBYTES; k++) begin
                    if (wr_strb[k]) begin
                        nxt[8*k +: 8] = wr_data[8*k +: 8];
                    end
                end
            end

            if (BYPASS != 0) begin : g_byp
                assign view[g] = we ? nxt : mem[g];
            end else begin : g_nobyp
                assign view[g] = mem[g];
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    mem[g] <= '0;
                end else if (we) begin
                    mem[g] <= nxt;
                end
            end
        end
    end

    // Read muxes; reset forces both ports to zero for the whole cycle.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_addr_a == ADDR_W'(i)) begin
                    rd_data_a = view[i];
                end
                if (rd_addr_b == ADDR_W'(i)) begin
                    rd_data_b = view[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_n.sv
// Directed bench for regfile_n: three instances (bypass+zero, plain, DEPTH=20)
// share the input stimulus; each output is checked against hand-computed values.
module tb_regfile_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] a0, b0, a1, b1, a2, b2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_n #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_strb(wr_strb), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(a0),
        .rd_addr_b(rd_addr_b), .rd_data_b(b0)
    );

    regfile_n #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_strb(wr_strb), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(a1),
        .rd_addr_b(rd_addr_b), .rd_data_b(b1)
    );

    regfile_n #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_strb(wr_strb), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(a2),
        .rd_addr_b(rd_addr_b), .rd_data_b(b2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_strb = s;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic sel(input logic [4:0] a, input logic [4:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_strb = '0; wr_data = '0;
        rd_addr_a = 5'd1; rd_addr_b = 5'd2;
        #1;
        check("rst_out_a", a0, 32'h0);
        check("rst_out_b", b0, 32'h0);
        step();
        reset = 1'b1;

        // Fill entries 1..31 then clear with a reset that collides with a write.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hDEADBEEF, 4'hF);
        sel(5'd1, 5'd31);
        check("fill_u1_a", a1, 32'hDEADBEEF);
        check("fill_u0_b", b0, 32'hDEADBEEF);
        sel(5'd19, 5'd20);
        check("fill_u2_19", a2, 32'hDEADBEEF);
        check("fill_u2_oor", b2, 32'h0);

        reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D; wr_strb = 4'hF;
        sel(5'd3, 5'd3);
        check("rst_cyc_a", a0, 32'h0);
        check("rst_cyc_b", b1, 32'h0);
        step();
        reset = 1'b1; wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sel(5'(i), 5'(31 - i));
            check("clr_u0_a", a0, 32'h0);
            check("clr_u0_b", b0, 32'h0);
            check("clr_u1_a", a1, 32'h0);
        end

        // Byte strobes.
        wr(5'd5, 32'h11223344, 4'hF);
        wr(5'd5, 32'hAABBCCDD, 4'b0101);
        sel(5'd5, 5'd5);
        check("strb_u0", a0, 32'h11BB33DD);
        check("strb_u1", b1, 32'h11BB33DD);
        check("strb_u2", a2, 32'h11BB33DD);
        wr(5'd5, 32'hFFFFFFFF, 4'h0);
        sel(5'd5, 5'd5);
        check("strb0_u1", a1, 32'h11BB33DD);
        check("strb0_u0", b0, 32'h11BB33DD);

        // Same-cycle bypass vs registered-only read.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; wr_strb = 4'hF;
        sel(5'd7, 5'd5);
        check("byp_u0", a0, 32'h12345678);
        check("nobyp_u1", a1, 32'h0);
        check("byp_other", b0, 32'h11BB33DD);
        step();
        wr_en = 1'b0;
        sel(5'd7, 5'd7);
        check("byp_next_u1", a1, 32'h12345678);
        check("byp_next_u0", b0, 32'h12345678);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h99887766; wr_strb = 4'b0010;
        sel(5'd5, 5'd5);
        check("byp_part_u0", a0, 32'h11BB77DD);
        check("nobyp_part_u1", a1, 32'h11BB33DD);
        step();
        wr_en = 1'b0;
        sel(5'd5, 5'd5);
        check("part_next_u1", a1, 32'h11BB77DD);

        // Zero register.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
        sel(5'd0, 5'd0);
        check("zero_byp_a", a0, 32'h0);
        check("zero_byp_b", b0, 32'h0);
        check("zero_u1_now", a1, 32'h0);
        step();
        wr_en = 1'b0;
        sel(5'd0, 5'd0);
        check("zero_u0_a", a0, 32'h0);
        check("zero_u0_b", b0, 32'h0);
        check("zero_u1_next", b1, 32'hFFFFFFFF);

        // Out-of-range write on DEPTH=20.
        wr(5'd19, 32'h01020304, 4'hF);
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h55555555; wr_strb = 4'hF;
        sel(5'd25, 5'd19);
        check("oor_byp", a2, 32'h0);
        step();
        wr_en = 1'b0;
        sel(5'd9, 5'd5);
        check("oor_mod16", a2, 32'h0);
        check("oor_mod20", b2, 32'h11BB77DD);
        sel(5'd25, 5'd19);
        check("oor_read", a2, 32'h0);
        check("last_entry", b2, 32'h01020304);

        // Reset mid-sequence; first write afterwards commits.
        wr(5'd10, 32'hABCD0001, 4'hF);
        reset = 1'b0;
        step();
        reset = 1'b1;
        sel(5'd10, 5'd7);
        check("mid_rst_lost", a1, 32'h0);
        check("mid_rst_7", b0, 32'h0);
        wr(5'd10, 32'h00000042, 4'hF);
        sel(5'd10, 5'd10);
        check("post_rst_u0", a0, 32'h00000042);
        check("post_rst_u1", b1, 32'h00000042);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
